proc_feeder: RTL and testbench

//  Host-side driver of the processor's DIN/Run/Done interface. It owns a small program store and

---
 rtl/proc_feeder_if.sv | 11 +
 rtl/proc_feeder.sv | 133 +++++++++++++
 tb/tb_proc_feeder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/proc_feeder_if.sv
// Processor-side DIN/Run/Done handshake between the program feeder and the core.
interface proc_feeder_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] DIN;
  logic             Run;
  logic             Done;

  modport master (output DIN, output Run, input Done);
  modport slave  (input DIN, input Run, output Done);
endinterface

// File: rtl/proc_feeder.sv
// Program-store feeder: issues stored words to the processor with a Run pulse and waits for Done.
// Optional Done watchdog (Error port, TIMEOUT parameter) enabled by defining FEEDER_WATCHDOG_EN.
module proc_feeder #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
`ifdef FEEDER_WATCHDOG_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [WIDTH-1:0]  ProgData,
  input  logic              Start,
  proc_feeder_if.master     cpu,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic [15:0]       InstrCount
`ifdef FEEDER_WATCHDOG_EN
  , output logic            Error
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [15:0]         cnt_n;
  logic                run;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    word;
  logic [2:0]          op;

`ifdef FEEDER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic            err_n;
`endif

  // Store is not reset; writes are only accepted while the feeder is not sequencing.
  always_ff @(posedge Clock) begin
    if (ProgWe && (state == S_IDLE || state == S_HALT))
      mem[ProgAddr] <= ProgData;
  end

  assign word   = mem[PC];
  assign op     = word[WIDTH-1 -: 3];
  assign Busy   = (state == S_ISSUE) || (state == S_WAIT);
  assign Halted = (state == S_HALT);
  assign cpu.DIN = Busy ? word : '0;
  assign cpu.Run = run;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      PC         <= '0;
      InstrCount <= '0;
`ifdef FEEDER_WATCHDOG_EN
      wd_cnt     <= '0;
      Error      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      PC         <= pc_n;
      InstrCount <= cnt_n;
`ifdef FEEDER_WATCHDOG_EN
      wd_cnt     <= wd_n;
      Error      <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = PC;
    cnt_n   = InstrCount;
    run     = 1'b0;
`ifdef FEEDER_WATCHDOG_EN
    wd_n    = wd_cnt;
    err_n   = Error;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_n = S_ISSUE;
          pc_n    = '0;
          cnt_n   = '0;
`ifdef FEEDER_WATCHDOG_EN
          err_n   = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (op == OP_HALT) begin
          state_n = S_HALT;
        end else begin
          run     = 1'b1;
          state_n = S_WAIT;
`ifdef FEEDER_WATCHDOG_EN
          wd_n    = '0;
`endif
          // mvi: step onto the immediate so it is on DIN throughout WAIT
          if (op == OP_MVI)
            pc_n = PC + 1'b1;
        end
      end
      S_WAIT: begin
        if (cpu.Done) begin
          pc_n    = PC + 1'b1;
          state_n = S_ISSUE;
          if (InstrCount != '1)
            cnt_n = InstrCount + 16'd1;
        end
`ifdef FEEDER_WATCHDOG_EN
        else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_proc_feeder.sv
// Directed bench for proc_feeder: program load, mvi sequencing, wrap, write gating, reset, watchdog.
module tb_proc_feeder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ProgWe;
  logic [4:0] ProgAddr;
  logic [8:0] ProgData;
  logic       Start;
  logic [4:0] PC;
  logic       Busy;
  logic       Halted;
  logic [15:0] InstrCount;
`ifdef FEEDER_WATCHDOG_EN
  logic       Error;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  proc_feeder_if #(.WIDTH(9)) cpu ();

  proc_feeder #(.WIDTH(9), .ADDR_W(5)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ProgWe     (ProgWe),
    .ProgAddr   (ProgAddr),
    .ProgData   (ProgData),
    .Start      (Start),
    .cpu        (cpu),
    .PC         (PC),
    .Busy       (Busy),
    .Halted     (Halted),
    .InstrCount (InstrCount)
`ifdef FEEDER_WATCHDOG_EN
    , .Error    (Error)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic write(input logic [4:0] a, input logic [8:0] d);
    ProgWe = 1'b1; ProgAddr = a; ProgData = d;
    tick();
    ProgWe = 1'b0;
  endtask

  // At an ISSUE cycle: check the Run, then the WAIT cycle, then Done two cycles after Run.
  task automatic step(input string tag, input logic [8:0] din, input logic [4:0] pc,
                      input bit mvi, input logic [8:0] imm);
    check({tag, "_run"}, 32'(cpu.Run), 1);
    check({tag, "_din"}, 32'(cpu.DIN), 32'(din));
    check({tag, "_pc"},  32'(PC), 32'(pc));
    tick();
    check({tag, "_wrun"}, 32'(cpu.Run), 0);
    check({tag, "_wdin"}, 32'(cpu.DIN), mvi ? 32'(imm) : 32'(din));
    check({tag, "_wpc"},  32'(PC), mvi ? 32'(pc + 5'd1) : 32'(pc));
    tick();
    cpu.Done = 1'b1;
    tick();
    cpu.Done = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ProgWe = 1'b0; ProgAddr = '0; ProgData = '0; Start = 1'b0; cpu.Done = 1'b0;
    tick(); tick();
    check("rst_din",  32'(cpu.DIN), 0);
    check("rst_run",  32'(cpu.Run), 0);
    check("rst_pc",   32'(PC), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_halt", 32'(Halted), 0);
    check("rst_cnt",  32'(InstrCount), 0);
    Reset = 1'b0;
    tick();

    // Basic program: mvi 005, mvi 003, add, halt
    write(5'd0, 9'h040); write(5'd1, 9'h005); write(5'd2, 9'h048);
    write(5'd3, 9'h003); write(5'd4, 9'h081); write(5'd5, 9'h1C0);
    Start = 1'b1; tick(); Start = 1'b0;
    step("p0", 9'h040, 5'd0, 1'b1, 9'h005);
    step("p1", 9'h048, 5'd2, 1'b1, 9'h003);
    step("p2", 9'h081, 5'd4, 1'b0, 9'h000);
    check("halt_issue_run", 32'(cpu.Run), 0);
    tick();
    check("halted",     32'(Halted), 1);
    check("halt_pc",    32'(PC), 5);
    check("halt_cnt",   32'(InstrCount), 3);
    check("halt_din",   32'(cpu.DIN), 0);
    check("halt_busy",  32'(Busy), 0);

    // Done alone in HALT is ignored
    cpu.Done = 1'b1; tick(); cpu.Done = 1'b0;
    check("hdone_halt", 32'(Halted), 1);
    check("hdone_cnt",  32'(InstrCount), 3);
    check("hdone_pc",   32'(PC), 5);

    // Start with Done in HALT: restart from 0, Done ignored
    Start = 1'b1; cpu.Done = 1'b1; tick(); cpu.Done = 1'b0;
    check("rs_run", 32'(cpu.Run), 1);
    check("rs_pc",  32'(PC), 0);
    check("rs_cnt", 32'(InstrCount), 0);
    tick();
    // Start held and a store write during WAIT: both ignored
    write(5'd2, 9'h081);
    tick();
    check("wait_pc",   32'(PC), 1);
    check("wait_run",  32'(cpu.Run), 0);
    check("wait_busy", 32'(Busy), 1);
    Start = 1'b0;
    cpu.Done = 1'b1; tick(); cpu.Done = 1'b0;
    step("drop", 9'h048, 5'd2, 1'b1, 9'h003);
    step("drop4", 9'h081, 5'd4, 1'b0, 9'h000);
    tick();
    check("drop_halt", 32'(Halted), 1);

    // Same write while HALT lands
    write(5'd2, 9'h081);
    Start = 1'b1; tick(); Start = 1'b0;
    step("land0", 9'h040, 5'd0, 1'b1, 9'h005);
    check("land_run", 32'(cpu.Run), 1);
    check("land_din", 32'(cpu.DIN), 'h081);
    check("land_pc",  32'(PC), 2);
    check("land_cnt", 32'(InstrCount), 1);
    tick();

    // Async reset in WAIT; store survives
    check("pre_rst_busy", 32'(Busy), 1);
    Reset = 1'b1; tick();
    check("mrst_din",  32'(cpu.DIN), 0);
    check("mrst_run",  32'(cpu.Run), 0);
    check("mrst_pc",   32'(PC), 0);
    check("mrst_busy", 32'(Busy), 0);
    check("mrst_halt", 32'(Halted), 0);
    Reset = 1'b0; tick();
    Start = 1'b1; tick(); Start = 1'b0;
    step("rb0", 9'h040, 5'd0, 1'b1, 9'h005);
    step("rb2", 9'h081, 5'd2, 1'b0, 9'h000);
    check("rb3_din", 32'(cpu.DIN), 'h003);
    Reset = 1'b1; tick(); Reset = 1'b0; tick();

    // PC wrap: mvi at 31 takes its immediate from address 0
    write(5'd0, 9'h1AA);
    for (int a = 1; a < 31; a++) write(5'(a), 9'h081);
    write(5'd31, 9'h040);
    Start = 1'b1; tick(); Start = 1'b0;
    for (int a = 0; a < 31; a++) begin
      check("walk_pc", 32'(PC), 32'(a));
      check("walk_run", 32'(cpu.Run), 1);
      tick(); tick();
      cpu.Done = 1'b1; tick(); cpu.Done = 1'b0;
    end
    check("wrap_run", 32'(cpu.Run), 1);
    check("wrap_din", 32'(cpu.DIN), 'h040);
    check("wrap_pc",  32'(PC), 31);
    check("wrap_cnt", 32'(InstrCount), 31);
    tick();
    check("wrap_imm", 32'(cpu.DIN), 'h1AA);
    check("wrap_pc0", 32'(PC), 0);
    Reset = 1'b1; tick(); Reset = 1'b0; tick();

`ifdef FEEDER_WATCHDOG_EN
    check("wd_err0", 32'(Error), 0);
    Start = 1'b1; tick(); Start = 1'b0;
    check("wd_run", 32'(cpu.Run), 1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      check("wd_wait_err",  32'(Error), 0);
      check("wd_wait_halt", 32'(Halted), 0);
    end
    tick();
    check("wd_err",  32'(Error), 1);
    check("wd_halt", 32'(Halted), 1);
    check("wd_pc",   32'(PC), 0);
    Start = 1'b1; tick(); Start = 1'b0;
    check("wd_clr", 32'(Error), 0);
    check("wd_rerun", 32'(cpu.Run), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
